// File: rtl/hzrd_scbd.sv
`default_nettype none
// ============================================================================
// Module   : hzrd_scbd
// Purpose  : Hazard-detection / scoreboard unit beside the decode stage of an
//            in-order integer pipeline. It tracks destination registers through
//            DEPTH post-decode stages and drives a one-hot forwarding select per
//            source operand. It stalls decode on load-use hazards that cannot
//            be forwarded yet, and on RAW / WAW / structural hazards against a
//            single long-latency multi-cycle (mul/div) unit.
// Ports    : i_clk, i_rst        clock, asynchronous active-high reset
//            i_rd_wen/i_rd_waddr decode destination
//            i_rs1/2_raddr       decode sources
//            i_is_load, i_is_mc  decode instruction class
//            i_mc_lat            multi-cycle latency (0 behaves as 1)
//            i_flush             decode instruction squashed
//            i_data_busy         pipeline frozen by a D-cache miss
//            o_if_id_halt        hold PC and IF/ID
//            o_id_ex_halt        inject bubble into EX
//            o_frwd_op1/2        one-hot forward select (0 = register file)
//            o_mc_busy           multi-cycle unit occupied
// Revision : 1.0 - initial release
// ============================================================================
module hzrd_scbd #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int LD_RDY = 1,
  parameter int MC_W   = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_wen,
  input  logic [ADDR_W-1:0] i_rd_waddr,
  input  logic [ADDR_W-1:0] i_rs1_raddr,
  input  logic [ADDR_W-1:0] i_rs2_raddr,
  input  logic              i_is_load,
  input  logic              i_is_mc,
  input  logic [MC_W-1:0]   i_mc_lat,
  input  logic              i_flush,
  input  logic              i_data_busy,
  output logic              o_if_id_halt,
  output logic              o_id_ex_halt,
  output logic [DEPTH-1:0]  o_frwd_op1,
  output logic [DEPTH-1:0]  o_frwd_op2,
  output logic              o_mc_busy
);

  // Tracking entries: index 0 is EX, index DEPTH-1 is the last stage before
  // register-file write.
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_load;
  logic [ADDR_W-1:0] ent_addr [DEPTH];

  logic [MC_W-1:0]   mc_cnt;
  logic [ADDR_W-1:0] mc_waddr;

  logic [DEPTH-1:0]  sel1;
  logic [DEPTH-1:0]  sel2;
  logic              ld_stall1;
  logic              ld_stall2;
  logic              mc_raw;
  logic              mc_waw;
  logic              mc_struct;
  logic              stall;
  logic              mc_issue;
  logic [MC_W-1:0]   mc_lat_eff;

  // Youngest-match search: walk from the oldest stage to the youngest so the
  // lowest-index match is the one left standing. A load match that is not yet
  // at a data-carrying stage turns into a stall instead of a forward.
  always_comb begin
    sel1      = '0;
    sel2      = '0;
    ld_stall1 = 1'b0;
    ld_stall2 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_valid[k] && (ent_addr[k] == i_rs1_raddr) && (i_rs1_raddr != '0)) begin
        sel1      = '0;
        ld_stall1 = ent_load[k] && (k < LD_RDY);
        if (!ld_stall1) begin
          sel1[k] = 1'b1;
        end
      end
      if (ent_valid[k] && (ent_addr[k] == i_rs2_raddr) && (i_rs2_raddr != '0)) begin
        sel2      = '0;
        ld_stall2 = ent_load[k] && (k < LD_RDY);
        if (!ld_stall2) begin
          sel2[k] = 1'b1;
        end
      end
    end
  end

  assign o_mc_busy = (mc_cnt != '0);

  // x0 never hazards, so a reader or writer of x0 never collides with the
  // multi-cycle destination.
  assign mc_raw    = o_mc_busy &&
                     (((i_rs1_raddr != '0) && (i_rs1_raddr == mc_waddr)) ||
                      ((i_rs2_raddr != '0) && (i_rs2_raddr == mc_waddr)));
  assign mc_waw    = o_mc_busy && i_rd_wen && (i_rd_waddr != '0) &&
                     (i_rd_waddr == mc_waddr);
  assign mc_struct = o_mc_busy && i_is_mc;

  assign stall = (ld_stall1 || ld_stall2 || mc_raw || mc_waw || mc_struct) && !i_flush;

  assign o_if_id_halt = stall;
  assign o_id_ex_halt = stall;
  assign o_frwd_op1   = stall ? '0 : sel1;
  assign o_frwd_op2   = stall ? '0 : sel2;

  assign mc_issue   = i_is_mc && !stall && !i_flush && !i_data_busy;
  assign mc_lat_eff = (i_mc_lat == '0) ? MC_W'(1) : i_mc_lat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ent_valid <= '0;
      ent_load  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ent_addr[k] <= '0;
      end
      mc_cnt   <= '0;
      mc_waddr <= '0;
    end else begin
      // Pipeline tracking advances only when the pipeline itself advances.
      if (!i_data_busy) begin
        for (int k = DEPTH - 1; k >= 1; k--) begin
          ent_valid[k] <= ent_valid[k-1];
          ent_load[k]  <= ent_load[k-1];
          ent_addr[k]  <= ent_addr[k-1];
        end
        // Multi-cycle results come from the MC unit, not the pipeline, so
        // they enter the pipeline as a bubble.
        ent_valid[0] <= !(stall || i_flush || i_is_mc) && i_rd_wen && (i_rd_waddr != '0);
        ent_load[0]  <= i_is_load;
        ent_addr[0]  <= i_rd_waddr;
      end
      // The MC unit keeps counting through a D-cache freeze.
      if (mc_issue) begin
        mc_cnt   <= mc_lat_eff;
        mc_waddr <= i_rd_waddr;
      end else if (mc_cnt != '0) begin
        mc_cnt <= mc_cnt - MC_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hzrd_scbd.sv
`default_nettype none
// ============================================================================
// Module   : tb_hzrd_scbd
// Purpose  : Self-checking bench for hzrd_scbd. A behavioural model (history
//            queue of decoded instructions plus an absolute "MC busy until
//            cycle" mark) predicts every output each cycle; directed sequences
//            add literal expectations, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hzrd_scbd;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 3;
  localparam int LD_RDY = 1;
  localparam int MC_W   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_wen = 1'b0;
  logic [ADDR_W-1:0] rd_waddr = '0;
  logic [ADDR_W-1:0] rs1 = '0;
  logic [ADDR_W-1:0] rs2 = '0;
  logic              is_load = 1'b0;
  logic              is_mc = 1'b0;
  logic [MC_W-1:0]   mc_lat = '0;
  logic              flush = 1'b0;
  logic              data_busy = 1'b0;
  logic              if_id_halt;
  logic              id_ex_halt;
  logic [DEPTH-1:0]  frwd1;
  logic [DEPTH-1:0]  frwd2;
  logic              mc_busy;

  always #5 clk = ~clk;

  hzrd_scbd #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LD_RDY(LD_RDY), .MC_W(MC_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_wen    (rd_wen),
    .i_rd_waddr  (rd_waddr),
    .i_rs1_raddr (rs1),
    .i_rs2_raddr (rs2),
    .i_is_load   (is_load),
    .i_is_mc     (is_mc),
    .i_mc_lat    (mc_lat),
    .i_flush     (flush),
    .i_data_busy (data_busy),
    .o_if_id_halt(if_id_halt),
    .o_id_ex_halt(id_ex_halt),
    .o_frwd_op1  (frwd1),
    .o_frwd_op2  (frwd2),
    .o_mc_busy   (mc_busy)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v;
    int a;
    bit ld;
  } ent_t;

  ent_t hist[$];     // hist[0] = instruction that entered EX most recently
  int   cyc;         // cycles since reset
  int   mc_last;     // last cycle in which the MC unit is busy
  int   mc_rd;
  int   tests = 0;
  int   fails = 0;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back('{v: 1'b0, a: 0, ld: 1'b0});
    cyc     = 0;
    mc_last = -1;
    mc_rd   = 0;
  endfunction

  function automatic int youngest(int rs);
    if (rs == 0) return -1;
    for (int k = 0; k < DEPTH; k++)
      if (hist[k].v && hist[k].a == rs) return k;
    return -1;
  endfunction

  function automatic void model_eval(output bit st, output int f1, output int f2,
                                     output bit busy);
    int k1;
    int k2;
    bit ls1;
    bit ls2;
    bit raw;
    bit waw;
    bit strc;
    busy = (cyc <= mc_last);
    k1   = youngest(int'(rs1));
    k2   = youngest(int'(rs2));
    ls1  = 1'b0;
    ls2  = 1'b0;
    f1   = 0;
    f2   = 0;
    if (k1 >= 0) begin
      ls1 = hist[k1].ld && (k1 < LD_RDY);
      if (!ls1) f1 = 1 << k1;
    end
    if (k2 >= 0) begin
      ls2 = hist[k2].ld && (k2 < LD_RDY);
      if (!ls2) f2 = 1 << k2;
    end
    raw  = busy && ((rs1 != 0 && int'(rs1) == mc_rd) || (rs2 != 0 && int'(rs2) == mc_rd));
    waw  = busy && rd_wen && rd_waddr != 0 && int'(rd_waddr) == mc_rd;
    strc = busy && is_mc;
    st   = (ls1 || ls2 || raw || waw || strc) && !flush;
    if (st) begin
      f1 = 0;
      f2 = 0;
    end
  endfunction

  function automatic void model_step();
    bit st;
    int f1;
    int f2;
    bit busy;
    model_eval(st, f1, f2, busy);
    if (!data_busy) begin
      hist.push_front('{v: !(st || flush || is_mc) && rd_wen && rd_waddr != 0,
                        a: int'(rd_waddr), ld: is_load});
      void'(hist.pop_back());
    end
    if (is_mc && !st && !flush && !data_busy) begin
      mc_last = cyc + ((mc_lat == 0) ? 1 : int'(mc_lat));
      mc_rd   = int'(rd_waddr);
    end
    cyc++;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    bit st;
    int f1;
    int f2;
    bit busy;
    forever begin
      @(negedge clk);
      model_eval(st, f1, f2, busy);
      check("if_id_halt", int'(if_id_halt), int'(st));
      check("id_ex_halt", int'(id_ex_halt), int'(st));
      check("frwd_op1", int'(frwd1), f1);
      check("frwd_op2", int'(frwd2), f2);
      check("mc_busy", int'(mc_busy), int'(busy));
    end
  end

  // ---------------- stimulus ----------------
  // Advances the model across the edge, then presents the next decode inputs;
  // returns at the following negedge, where outputs are stable.
  task automatic drive(input bit w, input int rd, input int r1, input int r2,
                       input bit ld, input bit mc, input int lat,
                       input bit fl, input bit db);
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    rd_wen    = w;
    rd_waddr  = ADDR_W'(rd);
    rs1       = ADDR_W'(r1);
    rs2       = ADDR_W'(r2);
    is_load   = ld;
    is_mc     = mc;
    mc_lat    = MC_W'(lat);
    flush     = fl;
    data_busy = db;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    idle();
    idle();
    check("reset halt", int'(if_id_halt), 0);
    check("reset frwd1", int'(frwd1), 0);
    check("reset busy", int'(mc_busy), 0);
    #2 rst = 1'b0;

    // ALU forwarding from EX, then from stage 1
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 5, 5, 0, 0, 0, 0, 0);
    check("alu fwd1 st0", int'(frwd1), 'b001);
    check("alu fwd2 st0", int'(frwd2), 'b001);
    check("alu no halt", int'(if_id_halt), 0);
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 6, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 5, 5, 0, 0, 0, 0, 0);
    check("alu fwd1 st1", int'(frwd1), 'b010);
    check("alu fwd2 st1", int'(frwd2), 'b010);

    // Load-use: one stall then forward from stage 1
    drive(1, 7, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 7, 0, 0, 0, 0, 0);
    check("ld-use halt", int'(id_ex_halt), 1);
    check("ld-use frwd2", int'(frwd2), 0);
    drive(0, 0, 0, 7, 0, 0, 0, 0, 0);
    check("ld-use release", int'(id_ex_halt), 0);
    check("ld-use fwd st1", int'(frwd2), 'b010);

    // Load-use across a 4-cycle D-cache freeze
    drive(1, 7, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 7, 0, 0, 0, 0, 1);
      check("frozen halt", int'(if_id_halt), 1);
    end
    drive(0, 0, 0, 7, 0, 0, 0, 0, 0);
    check("post-freeze halt", int'(if_id_halt), 1);
    drive(0, 0, 0, 7, 0, 0, 0, 0, 0);
    check("post-freeze fwd", int'(frwd2), 'b010);
    check("post-freeze go", int'(if_id_halt), 0);

    // MC RAW: latency 4 -> four stalled cycles
    drive(1, 9, 0, 0, 0, 1, 4, 0, 0);
    check("mc issue no halt", int'(if_id_halt), 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 9, 0, 0, 0, 0, 0, 0);
      check("mc raw halt", int'(if_id_halt), 1);
      check("mc raw busy", int'(mc_busy), 1);
    end
    drive(0, 0, 9, 0, 0, 0, 0, 0, 0);
    check("mc raw done", int'(if_id_halt), 0);
    check("mc idle", int'(mc_busy), 0);

    // MC structural: second MC op waits for the first (lat 3)
    drive(1, 10, 0, 0, 0, 1, 3, 0, 0);
    drive(1, 11, 0, 0, 0, 1, 2, 0, 0);
    check("mc struct halt", int'(if_id_halt), 1);
    drive(1, 11, 0, 0, 0, 1, 2, 0, 0);
    drive(1, 11, 0, 0, 0, 1, 2, 0, 0);
    drive(1, 11, 0, 0, 0, 1, 2, 0, 0);
    check("mc struct go", int'(if_id_halt), 0);
    idle();
    idle();
    idle();

    // x0 never hazards
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("x0 halt", int'(if_id_halt), 0);
    check("x0 frwd1", int'(frwd1), 0);

    // Flush beats load-use; the flushed slot becomes a bubble
    drive(1, 7, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 7, 0, 0, 0, 1, 0);
    check("flush no halt", int'(if_id_halt), 0);
    check("flush no frwd", int'(frwd2), 0);
    drive(0, 0, 7, 0, 0, 0, 0, 0, 0);
    check("flush bubble fwd", int'(frwd1), 'b010);

    // Asynchronous reset mid-cycle with MC busy (cnt=3) and valid entries
    drive(1, 12, 0, 0, 0, 1, 4, 0, 0);
    drive(1, 13, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 13, 12, 0, 0, 0, 0, 0);
    check("pre-rst halt", int'(if_id_halt), 1);
    check("pre-rst busy", int'(mc_busy), 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async rst halt", int'(if_id_halt), 0);
    check("async rst frwd1", int'(frwd1), 0);
    check("async rst frwd2", int'(frwd2), 0);
    check("async rst busy", int'(mc_busy), 0);
    drive(0, 0, 13, 12, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7), $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hzrd_scbd.md
# hzrd_scbd

Parametrised hazard-detection and scoreboard unit for the in-order integer pipeline, sitting beside the decode stage. It tracks destination registers through a configurable number of post-decode stages. It drives a one-hot forwarding select per source operand and stalls decode when a load result is not yet forwardable. It also tracks one long-latency multi-cycle unit (mul/div) and enforces RAW, WAW and structural stalls against it.

## Interface
- ADDR_W, 5: register address width; address 0 is hard-wired zero and never hazards.
- DEPTH, 3: tracked stages after decode; stage 0 = EX, stage DEPTH-1 = last stage before register-file write.
- LD_RDY, 1: lowest stage index whose output carries load data; must satisfy 0 ≤ LD_RDY ≤ DEPTH-1.
- MC_W, 6: width of the multi-cycle latency counter.

Ports:
- i_clk  in  1  global clock; one clock domain.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rd_wen  in  1  decode instruction writes the register file.
- i_rd_waddr  in  ADDR_W  decode destination register.
- i_rs1_raddr  in  ADDR_W  decode source 1.
- i_rs2_raddr  in  ADDR_W  decode source 2.
- i_is_load  in  1  decode instruction is a load.
- i_is_mc  in  1  decode instruction is a multi-cycle op; its result is written by the MC unit.
- i_mc_lat  in  MC_W  latency of that op in cycles; 0 is treated as 1.
- i_flush  in  1  decode instruction is squashed.
- i_data_busy  in  1  data-cache miss; pipeline frozen.
- o_if_id_halt  out  1  hold PC and IF/ID.
- o_id_ex_halt  out  1  inject bubble into EX.
- o_frwd_op1  out  DEPTH  one-hot forward select for rs1; bit k means forward from stage k output. All-zero selects the register file.
- o_frwd_op2  out  DEPTH  same for rs2.
- o_mc_busy  out  1  multi-cycle counter non-zero.

## Operation
- Each of the DEPTH tracking entries holds {valid, waddr, is_load}. valid = wen & waddr≠0.
- An entry k matches rsX when it is valid, waddr == rsX and rsX ≠ 0. Only the lowest-index (youngest) match counts.
- Youngest match with is_load=1 and k < LD_RDY gives ld_stall for that operand. Otherwise the match sets bit k of o_frwd_opX.
- mc_raw: o_mc_busy and rsX == mc_waddr (rsX≠0).
- mc_waw: o_mc_busy, i_rd_wen and i_rd_waddr == mc_waddr.
- mc_struct: o_mc_busy and i_is_mc.
- stall = (any ld_stall | mc_raw | mc_waw | mc_struct) & !i_flush. A flushed instruction never stalls.
- o_if_id_halt = o_id_ex_halt = stall. When stall=1 both o_frwd_op vectors are forced to zero.
- Shift on every edge with i_data_busy=0:
  - entry 0 is loaded as a bubble (valid=0) if stall | i_flush | i_is_mc;
  - otherwise entry 0 takes {wen&waddr≠0, waddr, is_load};
  - entry k takes entry k-1.
- When i_data_busy=1 the entries hold their values. Outputs stay combinational on the held state.
- MC issue happens when i_is_mc & !stall & !i_flush & !i_data_busy. On issue, mc_waddr is captured and cnt is loaded with max(i_mc_lat,1).
- cnt decrements by 1 on every edge while non-zero, independent of i_data_busy. o_mc_busy = cnt≠0.
- The MC unit writes the register file in the last busy cycle. No forwarding is done from it.

## Timing
- Reset (asynchronous): all entries invalid, cnt=0, mc_waddr=0. Result: all outputs 0.
- All outputs are combinational from the decode inputs and registered state. There is no output register.
- Load at stage 0 with LD_RDY=1 and a dependent in decode: exactly 1 stall cycle. The next cycle forwards from stage 1.
- MC issued at edge T with latency L: o_mc_busy is high for cycles T+1..T+L. A dependent reader stalls through T+L and proceeds at T+L+1.
- Simultaneous i_flush and hazard: flush wins, no stall, bubble enters entry 0.
- Simultaneous i_data_busy and stall: halts are still asserted and state is frozen.
- Reset asserted mid-MC-op clears cnt immediately.

## Test plan
- ALU x5 (wen, rd=5), then reader rs1=5, rs2=5 → o_frwd_op1=o_frwd_op2=3'b001, no halt. One cycle later with an unrelated instruction between → 3'b010.
- Load x7, then reader rs2=7 (LD_RDY=1) → halts=1 for one cycle, frwd=0. Next cycle o_frwd_op2=3'b010, halts=0.
- Load x7 plus reader, with i_data_busy=1 for 4 cycles → halts held at 1 throughout; after release, 1 cycle later forward 3'b010.
- MC op rd=9, lat=4, then reader rs1=9 → o_mc_busy high 4 cycles, halts high 4 cycles, reader proceeds on cycle 5. A second MC op while busy also stalls.
- x0 as destination or source, and i_flush=1 together with a load-use → no halt, no forward, entry 0 bubble.
- Reset asserted asynchronously mid-clock with cnt=3 and entries valid → all outputs 0 before the next edge.
